// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types and constants for the instruction-fetch queue.
//   ADDR_W / INSTR_W : address and instruction widths.
//   ifq_entry_t      : one queue entry, {pc_plus4, instr}, laid out like IF/ID.
//   NOP              : instruction word used on the IF/ID flush path.
//   ENTRY_RESET      : all-zero entry used to clear storage and head registers.
//   word_align()     : clears the byte-offset bits of a fetch address.
package ifq_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc_plus4;
        logic [INSTR_W-1:0] instr;
    } ifq_entry_t;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    localparam ifq_entry_t ENTRY_RESET = '{pc_plus4: 32'h0000_0000, instr: NOP};

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: synchronous FIFO of ifq_entry_t with a registered head.
//   clk, rst : clock and synchronous active-high reset.
//   push     : write wr_data at the tail.
//   pop      : retire the head entry (ignored when empty).
//   flush    : empty the queue and zero both pointers; wins over push/pop.
//   wr_data  : entry to write.
//   head     : registered head entry; holds its last value while empty.
//   count    : number of valid entries, 0..DEPTH.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  ifq_entry_t              wr_data,
    output ifq_entry_t              head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ifq_entry_t       mem_r [DEPTH];
    ifq_entry_t       head_r;
    ifq_entry_t       head_nxt_s;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Next pointers, count and head entry.
    always_comb begin
        pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
        // The upstream credit scheme never pushes into a full queue; this
        // guard only keeps storage intact if that contract is ever broken.
        push_ok_s = push && ((count_r != CNT_W'(DEPTH)) || pop_ok_s);

        if (flush) begin
            rd_ptr_nxt_s = {PTR_W{1'b0}};
            wr_ptr_nxt_s = {PTR_W{1'b0}};
            count_nxt_s  = {CNT_W{1'b0}};
        end else begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(pop_ok_s);
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(push_ok_s);
            count_nxt_s  = count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end

        // The head register tracks the entry at the next read pointer. When
        // that slot is being written this cycle the new word is taken straight
        // from wr_data. An empty queue keeps the last head visible.
        if (count_nxt_s == {CNT_W{1'b0}}) begin
            head_nxt_s = head_r;
        end else if (push_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = wr_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Pointer, count, head and storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            head_r   <= ENTRY_RESET;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= ENTRY_RESET;
            end
        end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            count_r  <= count_nxt_s;
            head_r   <= head_nxt_s;
            if (push_ok_s && !flush) begin
                mem_r[wr_ptr_r] <= wr_data;
            end
        end
    end

    assign head  = head_r;
    assign count = count_r;

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: decoupled instruction-fetch front end feeding IF/ID.
//   clk_i, rst_i         : clock, synchronous active-high reset.
//   mem_req_o/mem_addr_o : in-order fetch request and word-aligned address.
//   mem_gnt_i            : memory accepts the current request.
//   mem_rvalid_i/rdata_i : in-order response, one per grant.
//   redirect_i/_pc_i     : taken branch; flush the queue and restart fetch.
//   instr_valid_o        : head entry valid.
//   instr_o, pc_plus4_o  : head entry {instr, PC+4}.
//   instr_ready_i        : consumer takes the head this cycle.
// Requests are issued only while queued plus in-flight words fit in DEPTH,
// so every response that is kept always finds a free slot.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               mem_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [INSTR_W-1:0] mem_rdata_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_plus4_o,
    input  logic               instr_ready_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] resp_pc_r;
    logic [CNT_W-1:0]  inflight_r;
    // Responses still owed for requests issued before a redirect; they are
    // dropped on arrival.
    logic [CNT_W-1:0]  discard_r;

    logic [CNT_W-1:0]  count_s;
    logic [CNT_W:0]    used_s;
    logic              req_s;
    logic              grant_s;
    logic              rsp_ok_s;
    logic              inflight_dec_s;
    logic              discard_dec_s;
    logic              push_s;
    logic              pop_s;
    ifq_entry_t        wr_entry_s;
    ifq_entry_t        head_s;

    // Request credit and response bookkeeping.
    always_comb begin
        used_s  = {1'b0, count_s} + {1'b0, inflight_r};
        req_s   = !rst_i && !redirect_i && (used_s < (CNT_W + 1)'(DEPTH));
        grant_s = req_s && mem_gnt_i;

        // A response with nothing outstanding is a protocol error and is
        // ignored entirely.
        rsp_ok_s       = mem_rvalid_i && ((inflight_r != {CNT_W{1'b0}}) ||
                                          (discard_r  != {CNT_W{1'b0}}));
        discard_dec_s  = rsp_ok_s && (discard_r != {CNT_W{1'b0}});
        inflight_dec_s = rsp_ok_s && (discard_r == {CNT_W{1'b0}});

        push_s = inflight_dec_s && !redirect_i;
        pop_s  = instr_valid_o && instr_ready_i && !redirect_i;

        wr_entry_s.pc_plus4 = resp_pc_r + 32'd4;
        wr_entry_s.instr    = mem_rdata_i;
    end

    // Fetch/response PCs and outstanding-response counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            inflight_r <= {CNT_W{1'b0}};
            discard_r  <= {CNT_W{1'b0}};
        end else if (redirect_i) begin
            fetch_pc_r <= word_align(redirect_pc_i);
            resp_pc_r  <= word_align(redirect_pc_i);
            inflight_r <= {CNT_W{1'b0}};
            // Everything still in flight becomes a drop, minus the response
            // that arrives (and is dropped) in this very cycle.
            discard_r  <= discard_r + inflight_r - CNT_W'(rsp_ok_s);
        end else begin
            if (grant_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (push_s) begin
                resp_pc_r <= resp_pc_r + 32'd4;
            end
            inflight_r <= inflight_r + CNT_W'(grant_s) - CNT_W'(inflight_dec_s);
            discard_r  <= discard_r - CNT_W'(discard_dec_s);
        end
    end

    ifq_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (redirect_i),
        .wr_data (wr_entry_s),
        .head    (head_s),
        .count   (count_s)
    );

    assign mem_req_o     = req_s;
    assign mem_addr_o    = fetch_pc_r;
    assign instr_valid_o = (count_s != {CNT_W{1'b0}});
    assign instr_o       = head_s.instr;
    assign pc_plus4_o    = head_s.pc_plus4;

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: a queue-based behavioural model and a
// simple in-order memory with programmable latency, directed scenarios with
// literal expectations, then a randomized phase.
module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_plus4_o;
    logic        instr_ready_i = 1'b0;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_plus4_o    (pc_plus4_o),
        .instr_ready_i (instr_ready_i)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // behavioural model state
    logic [31:0] m_fetch, m_resp, m_last_instr, m_last_pc4;
    int          m_inflight, m_discard;
    logic [63:0] m_q[$];

    // memory model
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t       pend[$];
    int          cyc = 0;
    int          lat = 1;
    bit          resp_en = 1'b1;
    bit          spur = 1'b0;
    bit          chk_en = 1'b0;
    logic [31:0] glog[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] gl(input int i);
        if (i < glog.size()) return glog[i];
        else return 32'hDEAD_DEAD;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock cycle: drive inputs, compare DUT with model, advance model.
    task automatic cycle(input bit rst, input bit gnt, input bit rdy, input bit redir,
                         input logic [31:0] rpc);
        bit          rv, real_rsp, exp_req, grant, rsp_ok;
        logic [31:0] rd;
        @(negedge clk);
        rv = 1'b0; real_rsp = 1'b0; rd = 32'h0;
        if (!rst && resp_en && pend.size() > 0 && pend[0].due <= cyc) begin
            rv = 1'b1; real_rsp = 1'b1; rd = memf(pend[0].addr);
        end else if (!rst && spur) begin
            rv = 1'b1; rd = 32'hBAD0_BAD0;
        end
        rst_i = rst; mem_gnt_i = gnt; instr_ready_i = rdy; redirect_i = redir;
        redirect_pc_i = rpc; mem_rvalid_i = rv; mem_rdata_i = rd;
        #1;
        exp_req = !rst && !redir && (m_q.size() + m_inflight < DEPTH);
        if (chk_en) begin
            check("mem_req", {31'b0, mem_req_o}, {31'b0, exp_req});
            check("mem_addr", mem_addr_o, m_fetch);
            check("instr_valid", {31'b0, instr_valid_o}, {31'b0, (m_q.size() != 0)});
            check("instr", instr_o, m_last_instr);
            check("pc_plus4", pc_plus4_o, m_last_pc4);
        end
        grant = exp_req && gnt;
        if (grant) glog.push_back(mem_addr_o);
        if (real_rsp) void'(pend.pop_front());
        if (grant) pend.push_back('{m_fetch, cyc + lat});
        if (rst) begin
            m_fetch = RESET_PC; m_resp = RESET_PC; m_inflight = 0; m_discard = 0;
            m_q.delete(); pend.delete(); m_last_instr = 32'h0; m_last_pc4 = 32'h0;
        end else begin
            rsp_ok = rv && (m_inflight > 0 || m_discard > 0);
            if (redir) begin
                m_discard  = m_discard + m_inflight - (rsp_ok ? 1 : 0);
                m_inflight = 0;
                m_q.delete();
                m_fetch = rpc & 32'hFFFF_FFFC;
                m_resp  = rpc & 32'hFFFF_FFFC;
            end else begin
                if (rdy && m_q.size() > 0) void'(m_q.pop_front());
                if (rsp_ok) begin
                    if (m_discard > 0) m_discard--;
                    else begin
                        m_inflight--;
                        m_q.push_back({m_resp + 32'd4, rd});
                        m_resp = m_resp + 32'd4;
                    end
                end
                if (grant) begin
                    m_fetch = m_fetch + 32'd4;
                    m_inflight++;
                end
            end
            if (m_q.size() > 0) {m_last_pc4, m_last_instr} = m_q[0];
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input bit gnt, input bit rdy, input int budget, input string name);
        int i;
        i = 0;
        while (!instr_valid_o && i < budget) begin
            cycle(1'b0, gnt, rdy, 1'b0, 32'h0);
            i++;
        end
        check({name, "_valid"}, {31'b0, instr_valid_o}, 32'h1);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        bit prev_redir;
        bit rs, g, r, rd;

        // first reset cycle: DUT state undefined before the edge
        do_reset();
        chk_en = 1'b1;
        do_reset();
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_req", {31'b0, mem_req_o}, 32'h0);
        check("rst_valid", {31'b0, instr_valid_o}, 32'h0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc4", pc_plus4_o, 32'h0);

        // spurious response with nothing outstanding is ignored
        spur = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        spur = 1'b0;
        check("spur_valid", {31'b0, instr_valid_o}, 32'h0);
        check("spur_addr", mem_addr_o, 32'h0);

        // S1: streaming, 1-cycle latency, always ready
        glog.delete(); lat = 1; resp_en = 1'b1;
        wait_valid(1'b1, 1'b1, 10, "s1");
        check("s1_w0_instr", instr_o, memf(32'h0));
        check("s1_w0_pc4", pc_plus4_o, 32'h4);
        check("s1_model_pc4", m_last_pc4, 32'h4);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("s1_w1_instr", instr_o, memf(32'h4));
        check("s1_w1_pc4", pc_plus4_o, 32'h8);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("s1_w2_instr", instr_o, memf(32'h8));
        check("s1_w2_pc4", pc_plus4_o, 32'hC);
        check("s1_addr0", gl(0), 32'h0);
        check("s1_addr1", gl(1), 32'h4);
        check("s1_addr2", gl(2), 32'h8);

        // S2: stall fills exactly DEPTH entries
        do_reset(); glog.delete();
        repeat (12) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("s2_grants", glog.size(), 32'd4);
        check("s2_req_off", {31'b0, mem_req_o}, 32'h0);
        check("s2_model_count", m_q.size(), 32'd4);
        check("s2_head_instr", instr_o, memf(32'h0));
        check("s2_head_pc4", pc_plus4_o, 32'h4);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("s2_drain_pc4", pc_plus4_o, 32'h8);
        check("s2_req_resume", {31'b0, mem_req_o}, 32'h1);
        repeat (8) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        // S3: redirect with two responses in flight
        do_reset(); resp_en = 1'b0; lat = 1;
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("s3_model_inflight", m_inflight, 32'd2);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0103);
        check("s3_addr", mem_addr_o, 32'h0000_0100);
        check("s3_valid", {31'b0, instr_valid_o}, 32'h0);
        check("s3_model_discard", m_discard, 32'd2);
        resp_en = 1'b1;
        wait_valid(1'b1, 1'b0, 20, "s3");
        check("s3_instr", instr_o, memf(32'h100));
        check("s3_pc4", pc_plus4_o, 32'h104);

        // S4: redirect in the same cycle as a response
        do_reset(); resp_en = 1'b1; lat = 2;
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
        check("s4_rvalid_seen", {31'b0, mem_rvalid_i}, 32'h1);
        check("s4_model_discard", m_discard, 32'd1);
        check("s4_valid", {31'b0, instr_valid_o}, 32'h0);
        wait_valid(1'b1, 1'b0, 20, "s4");
        check("s4_instr", instr_o, memf(32'h200));
        check("s4_pc4", pc_plus4_o, 32'h204);

        // S5: reset mid-stream with three queued entries
        do_reset(); lat = 1;
        for (int i = 0; i < 20 && m_q.size() != 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("s5_model_count", m_q.size(), 32'd3);
        do_reset();
        check("s5_valid", {31'b0, instr_valid_o}, 32'h0);
        check("s5_instr", instr_o, 32'h0);
        check("s5_pc4", pc_plus4_o, 32'h0);
        check("s5_addr", mem_addr_o, RESET_PC);
        wait_valid(1'b1, 1'b1, 10, "s5");
        check("s5_first_pc4", pc_plus4_o, 32'h4);

        // S6: address wrap after redirect to the top word
        do_reset(); glog.delete();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check("s6_addr", mem_addr_o, 32'hFFFF_FFFC);
        wait_valid(1'b1, 1'b0, 10, "s6");
        check("s6_grant0", gl(0), 32'hFFFF_FFFC);
        check("s6_grant1", gl(1), 32'h0000_0000);
        check("s6_pc4", pc_plus4_o, 32'h0000_0000);
        check("s6_instr", instr_o, memf(32'hFFFF_FFFC));

        // randomized phase
        prev_redir = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            lat     = $urandom_range(1, 3);
            resp_en = ($urandom % 10) < 8;
            g  = ($urandom % 10) < 7;
            r  = ($urandom % 10) < 6;
            rs = ($urandom % 1000) < 4;
            if (prev_redir) rd = ($urandom % 2) == 0;
            else            rd = (m_discard == 0) && (($urandom % 100) < 4);
            cycle(rs, g, r, rd, $urandom);
            prev_redir = rd && !rs;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Decoupled instruction-fetch front end for the 5-stage pipelined CPU.
- Sits directly upstream of the IF/ID pipeline register and issues in-order requests to a variable-latency instruction memory.
- Buffers returned words with their PC+4 in a small FIFO and presents them to IF/ID under a valid/ready handshake.
- A taken branch (redirect) resolved in EX/MEM flushes the queue and restarts fetch at the target.

Parameters:
- DEPTH, 4, queue entries; also the maximum of queued plus in-flight requests; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- mem_req_o  output  1  fetch request valid.
- mem_addr_o  output  32  fetch byte address; always word aligned.
- mem_gnt_i  input  1  memory accepts the request this cycle.
- mem_rvalid_i  input  1  response valid; responses arrive in request order, one per grant, at least 1 cycle after the grant.
- mem_rdata_i  input  32  instruction word.
- redirect_i  input  1  taken branch: flush and restart.
- redirect_pc_i  input  32  restart address; bits [1:0] are ignored and treated as 0.
- instr_valid_o  output  1  head entry valid.
- instr_o  output  32  head instruction.
- pc_plus4_o  output  32  head PC+4, matching the IF/ID {PC+4, instr} layout.
- instr_ready_i  input  1  consumer takes the head; low means stall.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - Queue count=0, in-flight=0, discard=0.
  - Outputs: mem_req_o=0, instr_valid_o=0, instr_o=0, pc_plus4_o=0.
  - mem_addr_o=RESET_PC.
  - rst_i overrides redirect_i and every other input.
- Request issue:
  - mem_req_o = !rst_i && !redirect_i && (count + inflight < DEPTH).
  - mem_addr_o = fetch_pc.
  - Grant = mem_req_o & mem_gnt_i. On a grant: fetch_pc += 4 and inflight += 1.
  - mem_addr_o is held stable while mem_req_o=1 without a grant.
- Response handling:
  - Every mem_rvalid_i decrements inflight, or discard if discard>0.
  - A response is pushed only if discard==0 and redirect_i==0.
  - Push writes {resp_pc+4, mem_rdata_i} and sets resp_pc += 4.
  - mem_rvalid_i while inflight==0 and discard==0 is a protocol error: ignored, all state unchanged.
  - The credit rule guarantees a push never finds the queue full; no overflow path is needed.
- Output side:
  - instr_valid_o = (count != 0).
  - instr_o and pc_plus4_o are driven by the head entry.
  - Pop = instr_valid_o & instr_ready_i.
  - Head fields are stable while instr_valid_o=1 and instr_ready_i=0.
  - Empty queue: instr_o and pc_plus4_o hold their last values, or 0 after reset.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - Latency: a response pushed at edge N appears on instr_valid_o after edge N (registered FIFO, no bypass).
- Redirect (redirect_i=1, rst_i=0):
  - Next cycle: count=0, pointers=0, fetch_pc = resp_pc = {redirect_pc_i[31:2],2'b00}.
  - discard = inflight + grant_this_cycle(=0) - (mem_rvalid_i ? 1 : 0), plus the old discard value.
  - inflight=0.
  - Any pop in the redirect cycle is ignored; the queue is flushed.
  - Back-to-back redirects: the last one wins; discard keeps accumulating.
- Counter widths are $clog2(DEPTH)+1 bits. Addresses wrap modulo 2^32, so 32'hFFFF_FFFC+4 = 0.

Decomposition:
- Package ifq_pkg:
  - ADDR_W=32, INSTR_W=32.
  - Entry typedef {pc_plus4[31:0], instr[31:0]}.
  - NOP constant 32'h0000_0000 for the IF/ID flush path.
- One sub-module, ifq_fifo:
  - Synchronous FIFO with parameter DEPTH.
  - Ports: push, pop, flush, count.
  - Synchronous reset and flush.
- Top level holds fetch_pc, resp_pc, the inflight/discard counters and the request logic.

Test Plan:
- Reset, then mem_gnt_i=1 with 1-cycle response latency and instr_ready_i=1:
  - Addresses 0,4,8,... are issued.
  - Outputs (instr, pc_plus4) are (W0,4), (W1,8), (W2,12) on consecutive cycles after the initial fill.
- instr_ready_i=0, mem_gnt_i=1, DEPTH=4:
  - Exactly 4 grants occur, then mem_req_o=0.
  - count=4, and the head stays (W0,4) for 10 cycles.
  - Raising ready drains the entries in order, and requests resume.
- Redirect to 32'h0000_0103 with 2 responses in flight:
  - Next cycle mem_addr_o=32'h100, instr_valid_o=0.
  - The next 2 responses are dropped.
  - The first output afterwards is (M[0x100], 32'h104).
- Redirect asserted in the same cycle as mem_rvalid_i:
  - That response is not pushed, and discard counts it correctly.
  - No stale word ever appears.
- rst_i asserted mid-stream with the queue at count=3:
  - Next cycle all outputs are 0, fetch restarts at RESET_PC, and no pre-reset word is emitted.
- Redirect to 32'hFFFF_FFFC: addresses issued are FFFF_FFFC then 0000_0000, and the first pc_plus4_o is 32'h0000_0000.
